// File: rtl/seq_alu_if.sv
// seq_alu_if: bundles the start/busy/done handshake, the operation select,
// the operands, and the registered results/flags of seq_alu.
//
// Handshake: the control unit raises iStart together with iCtrl/iA/iB.
// The request is accepted on the first rising edge on which oBusy is low,
// which means the ALU is in IDLE or DONE. Operands and iCtrl are captured on
// that edge. oBusy stays high while a MUL/DIV is iterating, and iStart is
// ignored during that time. oDone pulses for exactly one cycle. From the
// oDone cycle onward, oC_hi/oC_lo/oZero/oNeg/oDivZero hold the new result
// until the next oDone.
//
// Modports:
//   master - control unit (drives iStart/iCtrl/iA/iB, observes results)
//   slave  - the ALU itself
interface seq_alu_if #(
  parameter int DATA_W = 32
);
  logic              iStart;
  logic [3:0]        iCtrl;
  logic [DATA_W-1:0] iA;
  logic [DATA_W-1:0] iB;
  logic              oBusy;
  logic              oDone;
  logic [DATA_W-1:0] oC_hi;
  logic [DATA_W-1:0] oC_lo;
  logic              oZero;
  logic              oNeg;
  logic              oDivZero;

  modport master (
    output iStart, iCtrl, iA, iB,
    input  oBusy, oDone, oC_hi, oC_lo, oZero, oNeg, oDivZero
  );

  modport slave (
    input  iStart, iCtrl, iA, iB,
    output oBusy, oDone, oC_hi, oC_lo, oZero, oNeg, oDivZero
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU.
// - Single-cycle ops (add/sub/logic/shift/rotate/not/neg) finish in one cycle.
// - MUL is an iterative radix-2 shift-add multiplier.
// - DIV is an iterative restoring divider.
// - Results and flags are registered and held until the next oDone.
//
// Ports:
//   iClk      - rising-edge clock
//   nRst      - asynchronous active-low reset
//   bus       - seq_alu_if.slave: iStart/iCtrl/iA/iB in;
//               oBusy/oDone/oC_hi/oC_lo/oZero/oNeg/oDivZero out
//   dbg_state - current FSM state (0 IDLE, 1 ITER, 2 FIX, 3 DONE)
module seq_alu #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic       iClk,
  input  logic       nRst,
  seq_alu_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam logic [3:0] CTRL_ALU_ADD = 4'd0;
  localparam logic [3:0] CTRL_ALU_SUB = 4'd1;
  localparam logic [3:0] CTRL_ALU_AND = 4'd2;
  localparam logic [3:0] CTRL_ALU_OR  = 4'd3;
  localparam logic [3:0] CTRL_ALU_XOR = 4'd4;
  localparam logic [3:0] CTRL_ALU_NOT = 4'd5;
  localparam logic [3:0] CTRL_ALU_NEG = 4'd6;
  localparam logic [3:0] CTRL_ALU_SLL = 4'd7;
  localparam logic [3:0] CTRL_ALU_SRL = 4'd8;
  localparam logic [3:0] CTRL_ALU_SRA = 4'd9;
  localparam logic [3:0] CTRL_ALU_ROL = 4'd10;
  localparam logic [3:0] CTRL_ALU_ROR = 4'd11;
  localparam logic [3:0] CTRL_ALU_MUL = 4'd12;
  localparam logic [3:0] CTRL_ALU_DIV = 4'd13;

  localparam int                  CNT_LAST = DATA_W - 1;
  localparam logic [SHAMT_W-1:0]  CNT_INIT = CNT_LAST[SHAMT_W-1:0];
  localparam logic [SHAMT_W-1:0]  CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_W:0]    WIDTH_C  = DATA_W[SHAMT_W:0];
  localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] ONE_2W   = {{(2*DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Magnitude as an unsigned value; the most-negative word maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? neg_w(v) : v;
  endfunction

  state_t              state_q, state_d;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                is_div_q, sign_a_q, sign_b_q, b_zero_q;
  logic [DATA_W-1:0]   a_q, opnd_q, hi_q, lo_q;
  logic [DATA_W-1:0]   c_hi_q, c_lo_q;
  logic                zero_q, neg_q, divz_q;

  logic                accept, op_mul, op_div, op_multi;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   alu_lo;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod_mag, prod_fix;
  logic [DATA_W-1:0]   fix_hi, fix_lo;
  logic                fix_neg;

  // DONE accepts a new request just like IDLE, so ops can run back to back.
  assign accept   = bus.iStart && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign op_mul   = (bus.iCtrl == CTRL_ALU_MUL);
  assign op_div   = (bus.iCtrl == CTRL_ALU_DIV);
  assign op_multi = op_mul || op_div;
  assign shamt    = bus.iB[SHAMT_W-1:0];

  always_comb begin
    alu_lo = '0;
    case (bus.iCtrl)
      CTRL_ALU_ADD: alu_lo = bus.iA + bus.iB;
      CTRL_ALU_SUB: alu_lo = bus.iA - bus.iB;
      CTRL_ALU_AND: alu_lo = bus.iA & bus.iB;
      CTRL_ALU_OR:  alu_lo = bus.iA | bus.iB;
      CTRL_ALU_XOR: alu_lo = bus.iA ^ bus.iB;
      CTRL_ALU_NOT: alu_lo = ~bus.iA;
      CTRL_ALU_NEG: alu_lo = neg_w(bus.iA);
      CTRL_ALU_SLL: alu_lo = bus.iA << shamt;
      CTRL_ALU_SRL: alu_lo = bus.iA >> shamt;
      CTRL_ALU_SRA: alu_lo = $signed(bus.iA) >>> shamt;
      // A shift by the full width yields 0, so amount 0 leaves iA unchanged.
      CTRL_ALU_ROL: alu_lo = (bus.iA << shamt) | (bus.iA >> (WIDTH_C - {1'b0, shamt}));
      CTRL_ALU_ROR: alu_lo = (bus.iA >> shamt) | (bus.iA << (WIDTH_C - {1'b0, shamt}));
      default:      alu_lo = '0;
    endcase
  end

  // One iteration step. {hi_q,lo_q} is the working pair for both operations.
  // MUL: hi_q accumulates the partial product, lo_q shifts out multiplier
  //      bits and shifts in product bits.
  // DIV: hi_q is the partial remainder, lo_q shifts out dividend bits and
  //      shifts in quotient bits.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_hi   = hi_q;
    step_lo   = lo_q;
    if (is_div_q) begin
      if (!div_diff[DATA_W]) begin
        step_hi = div_diff[DATA_W-1:0];
        step_lo = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[DATA_W-1:0];
        step_lo = {lo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], lo_q[DATA_W-1:1]};
    end
  end

  // Sign correction. The quotient takes sign(a)^sign(b); the remainder
  // takes the dividend's sign.
  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? (~prod_mag + ONE_2W) : prod_mag;
    fix_hi   = prod_fix[2*DATA_W-1:DATA_W];
    fix_lo   = prod_fix[DATA_W-1:0];
    fix_neg  = prod_fix[2*DATA_W-1];
    if (is_div_q) begin
      if (b_zero_q) begin
        fix_lo = '1;
        fix_hi = a_q;
      end else begin
        fix_lo = (sign_a_q ^ sign_b_q) ? neg_w(lo_q) : lo_q;
        fix_hi = sign_a_q ? neg_w(hi_q) : hi_q;
      end
      fix_neg = fix_lo[DATA_W-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? (op_multi ? S_ITER : S_DONE) : S_IDLE;
      S_ITER:         if (cnt_q == '0) state_d = S_FIX;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      c_hi_q   <= '0;
      c_lo_q   <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (op_multi) begin
              is_div_q <= op_div;
              sign_a_q <= bus.iA[DATA_W-1];
              sign_b_q <= bus.iB[DATA_W-1];
              b_zero_q <= (bus.iB == '0);
              a_q      <= bus.iA;
              hi_q     <= '0;
              cnt_q    <= CNT_INIT;
              opnd_q   <= op_div ? mag_w(bus.iB) : mag_w(bus.iA);
              lo_q     <= op_div ? mag_w(bus.iA) : mag_w(bus.iB);
            end else begin
              c_hi_q <= '0;
              c_lo_q <= alu_lo;
              zero_q <= (alu_lo == '0);
              neg_q  <= alu_lo[DATA_W-1];
              divz_q <= 1'b0;
            end
          end
        end
        S_ITER: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q - CNT_ONE;
        end
        S_FIX: begin
          c_hi_q <= fix_hi;
          c_lo_q <= fix_lo;
          zero_q <= ({fix_hi, fix_lo} == '0);
          neg_q  <= fix_neg;
          divz_q <= is_div_q && b_zero_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.oBusy    = (state_q == S_ITER) || (state_q == S_FIX);
  assign bus.oDone    = (state_q == S_DONE);
  assign bus.oC_hi    = c_hi_q;
  assign bus.oC_lo    = c_lo_q;
  assign bus.oZero    = zero_q;
  assign bus.oNeg     = neg_q;
  assign bus.oDivZero = divz_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam logic [3:0] C_ADD = 4'd0;
  localparam logic [3:0] C_SUB = 4'd1;
  localparam logic [3:0] C_AND = 4'd2;
  localparam logic [3:0] C_OR  = 4'd3;
  localparam logic [3:0] C_XOR = 4'd4;
  localparam logic [3:0] C_NOT = 4'd5;
  localparam logic [3:0] C_NEG = 4'd6;
  localparam logic [3:0] C_SLL = 4'd7;
  localparam logic [3:0] C_SRL = 4'd8;
  localparam logic [3:0] C_SRA = 4'd9;
  localparam logic [3:0] C_ROL = 4'd10;
  localparam logic [3:0] C_ROR = 4'd11;
  localparam logic [3:0] C_MUL = 4'd12;
  localparam logic [3:0] C_DIV = 4'd13;

  logic iClk = 1'b0;
  logic nRst;
  logic [1:0] dbg32, dbg16;
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset / DUTs ----------------
  always #5 iClk = ~iClk;

  seq_alu_if #(.DATA_W(32)) bus32 ();
  seq_alu_if #(.DATA_W(16)) bus16 ();

  seq_alu #(.DATA_W(32)) dut32 (.iClk(iClk), .nRst(nRst), .bus(bus32), .dbg_state(dbg32));
  seq_alu #(.DATA_W(16)) dut16 (.iClk(iClk), .nRst(nRst), .bus(bus16), .dbg_state(dbg16));

  // ---------------- stimulus tables ----------------
  logic [3:0]  s_ctrl [16] = '{C_SUB, C_AND, C_OR, C_XOR, C_NOT, C_NEG, C_NEG, C_SLL,
                               C_SRL, C_SRA, C_SRA, C_ROL, C_ROR, C_ROR, C_ROL, 4'd15};
  logic [31:0] s_a    [16] = '{32'h3, 32'hF0F0F0F0, 32'hF0000000, 32'hFFFF0000,
                               32'h0000FFFF, 32'h1, 32'h0, 32'h1,
                               32'h80000000, 32'h80000000, 32'h40000000, 32'h80000001,
                               32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
  logic [31:0] s_b    [16] = '{32'h5, 32'h0FF00FF0, 32'h0000000F, 32'h0F0F0F0F,
                               32'h12345678, 32'h0, 32'h0, 32'h1F,
                               32'h4, 32'h24, 32'h4, 32'h1,
                               32'h4, 32'h20, 32'h8, 32'h9};
  logic [31:0] s_exp  [16] = '{32'hFFFFFFFE, 32'h00F000F0, 32'hF000000F, 32'hF0F00F0F,
                               32'hFFFF0000, 32'hFFFFFFFF, 32'h0, 32'h80000000,
                               32'h08000000, 32'hF8000000, 32'h04000000, 32'h00000003,
                               32'h81234567, 32'h12345678, 32'h34567812, 32'h0};

  logic [31:0] d_a  [4] = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'd100};
  logic [31:0] d_b  [4] = '{32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7};
  logic [31:0] d_q  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14};
  logic [31:0] d_r  [4] = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'd2};
  logic        d_n  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic [3:0]  w_ctrl [4] = '{C_MUL, C_MUL, C_DIV, C_DIV};
  logic [15:0] w_a    [4] = '{16'hFFFD, 16'h8000, 16'hFFF9, 16'h0007};
  logic [15:0] w_b    [4] = '{16'h0007, 16'h8000, 16'h0002, 16'hFFFE};
  logic [15:0] w_hi   [4] = '{16'hFFFF, 16'h4000, 16'hFFFF, 16'h0001};
  logic [15:0] w_lo   [4] = '{16'hFFEB, 16'h0000, 16'hFFFD, 16'hFFFD};
  logic        w_n    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue32(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    bus32.iCtrl  = ctrl;
    bus32.iA     = a;
    bus32.iB     = b;
    bus32.iStart = 1'b1;
    @(posedge iClk); #1;
    bus32.iStart = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b);
    bus16.iCtrl  = ctrl;
    bus16.iA     = a;
    bus16.iB     = b;
    bus16.iStart = 1'b1;
    @(posedge iClk); #1;
    bus16.iStart = 1'b0;
  endtask

  // lat = number of edges from the accepting edge to the edge on which
  // oDone is first seen; n0 is how many edges have already elapsed.
  task automatic wait32(input int n0, output int lat, output int busy_n);
    lat = n0;
    busy_n = 0;
    while (bus32.oDone !== 1'b1 && lat < 200) begin
      if (bus32.oBusy === 1'b1) busy_n++;
      @(posedge iClk); #1;
      lat++;
    end
  endtask

  task automatic wait16(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (bus16.oDone !== 1'b1 && lat < 200) begin
      if (bus16.oBusy === 1'b1) busy_n++;
      @(posedge iClk); #1;
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nRst = 1'b0;
    bus32.iStart = 1'b0; bus32.iCtrl = '0; bus32.iA = '0; bus32.iB = '0;
    bus16.iStart = 1'b0; bus16.iCtrl = '0; bus16.iA = '0; bus16.iB = '0;
    repeat (3) @(posedge iClk);
    #1;
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if ({bus32.oBusy, bus32.oDone, bus32.oZero, bus32.oNeg, bus32.oDivZero} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {bus32.oBusy, bus32.oDone, bus32.oZero, bus32.oNeg, bus32.oDivZero}); end
    checks++; if (dbg32 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg32); end
    checks++; if ({bus16.oC_hi, bus16.oC_lo, bus16.oDone, bus16.oBusy} !== 34'h0) begin errors++; $display("FAIL reset_w16 got %h exp 0", {bus16.oC_hi, bus16.oC_lo}); end
    nRst = 1'b1;
    @(posedge iClk); #1;
  endtask

  task automatic test_add();
    int lat, busy_n;
    issue32(C_ADD, 32'h5, 32'hFFFFFFFB);
    wait32(1, lat, busy_n);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
    checks++; if (busy_n !== 0) begin errors++; $display("FAIL add_busy got %0d exp 0", busy_n); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'h0) begin errors++; $display("FAIL add_result got %h exp 0", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if ({bus32.oZero, bus32.oNeg} !== 2'b10) begin errors++; $display("FAIL add_flags got %b exp 10", {bus32.oZero, bus32.oNeg}); end
  endtask

  task automatic test_single_ops();
    int lat, busy_n;
    for (int i = 0; i < 16; i++) begin
      issue32(s_ctrl[i], s_a[i], s_b[i]);
      wait32(1, lat, busy_n);
      checks++; if (lat !== 1) begin errors++; $display("FAIL single[%0d]_latency got %0d exp 1", i, lat); end
      checks++; if (bus32.oC_lo !== s_exp[i]) begin errors++; $display("FAIL single[%0d]_lo got %h exp %h", i, bus32.oC_lo, s_exp[i]); end
      checks++; if (bus32.oC_hi !== 32'h0) begin errors++; $display("FAIL single[%0d]_hi got %h exp 0", i, bus32.oC_hi); end
      checks++; if (bus32.oZero !== (s_exp[i] == 32'h0)) begin errors++; $display("FAIL single[%0d]_zero got %b exp %b", i, bus32.oZero, (s_exp[i] == 32'h0)); end
    end
    // SUB 3-5 gives a negative result.
    issue32(C_SUB, 32'h3, 32'h5);
    wait32(1, lat, busy_n);
    checks++; if (bus32.oNeg !== 1'b1) begin errors++; $display("FAIL sub_neg got %b exp 1", bus32.oNeg); end
  endtask

  task automatic test_mul();
    int lat, busy_n;
    issue32(C_ADD, 32'h11, 32'h22);
    wait32(1, lat, busy_n);
    checks++; if (bus32.oC_lo !== 32'h33) begin errors++; $display("FAIL pre_mul_add got %h exp 33", bus32.oC_lo); end

    issue32(C_MUL, 32'hFFFFFFFD, 32'h7);
    wait32(1, lat, busy_n);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got %0d exp 34", lat); end
    checks++; if (busy_n !== 33) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 33", busy_n); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mul_neg3x7 got %h exp ffffffffffffffeb", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if ({bus32.oNeg, bus32.oZero, bus32.oDivZero} !== 3'b100) begin errors++; $display("FAIL mul_neg3x7_flags got %b exp 100", {bus32.oNeg, bus32.oZero, bus32.oDivZero}); end

    issue32(C_MUL, 32'h80000000, 32'h80000000);
    repeat (4) @(posedge iClk);
    #1;
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mul_hold got %h exp ffffffffffffffeb", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if ({bus32.oBusy, bus32.oDone} !== 2'b10) begin errors++; $display("FAIL mul_midbusy got %b exp 10", {bus32.oBusy, bus32.oDone}); end
    wait32(5, lat, busy_n);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mul_minmin_latency got %0d exp 34", lat); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'h40000000_00000000) begin errors++; $display("FAIL mul_minmin got %h exp 4000000000000000", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if (bus32.oNeg !== 1'b0) begin errors++; $display("FAIL mul_minmin_neg got %b exp 0", bus32.oNeg); end
  endtask

  task automatic test_div();
    int lat, busy_n;
    for (int i = 0; i < 4; i++) begin
      issue32(C_DIV, d_a[i], d_b[i]);
      wait32(1, lat, busy_n);
      checks++; if (lat !== 34) begin errors++; $display("FAIL div[%0d]_latency got %0d exp 34", i, lat); end
      checks++; if (bus32.oC_lo !== d_q[i]) begin errors++; $display("FAIL div[%0d]_quot got %h exp %h", i, bus32.oC_lo, d_q[i]); end
      checks++; if (bus32.oC_hi !== d_r[i]) begin errors++; $display("FAIL div[%0d]_rem got %h exp %h", i, bus32.oC_hi, d_r[i]); end
      checks++; if ({bus32.oNeg, bus32.oDivZero} !== {d_n[i], 1'b0}) begin errors++; $display("FAIL div[%0d]_flags got %b exp %b", i, {bus32.oNeg, bus32.oDivZero}, {d_n[i], 1'b0}); end
    end
  endtask

  task automatic test_div_zero();
    int lat, busy_n;
    issue32(C_DIV, 32'h1234, 32'h0);
    wait32(1, lat, busy_n);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divzero_latency got %0d exp 34", lat); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'h00001234_FFFFFFFF) begin errors++; $display("FAIL divzero_result got %h exp 00001234ffffffff", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if (bus32.oDivZero !== 1'b1) begin errors++; $display("FAIL divzero_flag got %b exp 1", bus32.oDivZero); end
    issue32(C_XOR, 32'hFF, 32'h0F);
    wait32(1, lat, busy_n);
    checks++; if (bus32.oDivZero !== 1'b0) begin errors++; $display("FAIL divzero_clear got %b exp 0", bus32.oDivZero); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'hF0) begin errors++; $display("FAIL divzero_xor got %h exp f0", {bus32.oC_hi, bus32.oC_lo}); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue32(C_MUL, 32'd6, 32'd7);
    lat = 1;
    while (bus32.oDone !== 1'b1 && lat < 200) begin
      if (lat == 10) begin
        bus32.iA = 32'd99; bus32.iB = 32'd99; bus32.iCtrl = C_ADD; bus32.iStart = 1'b1;
      end else begin
        bus32.iStart = 1'b0;
      end
      @(posedge iClk); #1;
      lat++;
    end
    bus32.iStart = 1'b0;
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_mul_latency got %0d exp 34", lat); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'd42) begin errors++; $display("FAIL b2b_mul_result got %h exp 2a", {bus32.oC_hi, bus32.oC_lo}); end
    // Request held in the oDone cycle is accepted immediately.
    issue32(C_SRA, 32'h80000000, 32'h4);
    checks++; if (bus32.oDone !== 1'b1) begin errors++; $display("FAIL b2b_sra_done got %b exp 1", bus32.oDone); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'hF8000000) begin errors++; $display("FAIL b2b_sra_result got %h exp f8000000", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if (bus32.oNeg !== 1'b1) begin errors++; $display("FAIL b2b_sra_neg got %b exp 1", bus32.oNeg); end
    @(posedge iClk); #1;
    checks++; if ({bus32.oDone, dbg32} !== 3'b000) begin errors++; $display("FAIL b2b_single_pulse got %b exp 000", {bus32.oDone, dbg32}); end
  endtask

  task automatic test_reset_mid_op();
    int lat, busy_n, dones;
    issue32(C_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge iClk);
    #3;
    nRst = 1'b0;
    #1;
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'h0) begin errors++; $display("FAIL async_reset_result got %h exp 0", {bus32.oC_hi, bus32.oC_lo}); end
    checks++; if ({bus32.oBusy, bus32.oDone, bus32.oNeg, bus32.oZero, dbg32} !== 6'b0) begin errors++; $display("FAIL async_reset_flags got %b exp 000000", {bus32.oBusy, bus32.oDone, bus32.oNeg, bus32.oZero, dbg32}); end
    @(posedge iClk); #1;
    nRst = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge iClk); #1;
      if (bus32.oDone === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL reset_abort_done got %0d exp 0", dones); end
    issue32(C_MUL, 32'd3, 32'd4);
    wait32(1, lat, busy_n);
    checks++; if (lat !== 34) begin errors++; $display("FAIL post_reset_mul_latency got %0d exp 34", lat); end
    checks++; if ({bus32.oC_hi, bus32.oC_lo} !== 64'd12) begin errors++; $display("FAIL post_reset_mul got %h exp c", {bus32.oC_hi, bus32.oC_lo}); end
  endtask

  task automatic test_width16();
    int lat, busy_n;
    for (int i = 0; i < 4; i++) begin
      issue16(w_ctrl[i], w_a[i], w_b[i]);
      wait16(lat, busy_n);
      checks++; if (lat !== 18) begin errors++; $display("FAIL w16[%0d]_latency got %0d exp 18", i, lat); end
      checks++; if (busy_n !== 17) begin errors++; $display("FAIL w16[%0d]_busy got %0d exp 17", i, busy_n); end
      checks++; if ({bus16.oC_hi, bus16.oC_lo} !== {w_hi[i], w_lo[i]}) begin errors++; $display("FAIL w16[%0d]_result got %h exp %h", i, {bus16.oC_hi, bus16.oC_lo}, {w_hi[i], w_lo[i]}); end
      checks++; if (bus16.oNeg !== w_n[i]) begin errors++; $display("FAIL w16[%0d]_neg got %b exp %b", i, bus16.oNeg, w_n[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_single_ops();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, clocked successor to the processor's combinational ALU.
- Single-cycle ops: add/sub/logic/shift/rotate/not/neg. These complete in 1 cycle.
- MUL and DIV run as iterative multi-cycle operations (radix-2 shift-add, restoring divide). This removes the large combinational multiplier and divider.
- Results and flags are registered and held.
- The control unit starts an operation with a start/busy/done handshake and stalls on oBusy.

Parameters:
DATA_W, 32, operand and result word width; must be ≥4 and a power of two.
SHAMT_W, $clog2(DATA_W), shift/rotate amount width taken from iB[SHAMT_W-1:0].

Ports:
iClk  in  1  clock, rising-edge.
nRst  in  1  asynchronous, active-low reset.
iStart  in  1  start request; sampled on a rising edge when oBusy=0.
iCtrl  in  4  operation select; shared CTRL_ALU_* encoding from the ALU control header.
iA  in  DATA_W  operand A.
iB  in  DATA_W  operand B.
oBusy  out  1  high while a MUL/DIV iteration is in progress.
oDone  out  1  one-cycle pulse: results valid from this cycle on.
oC_hi  out  DATA_W  MUL upper product / DIV remainder; 0 for all other ops.
oC_lo  out  DATA_W  primary result / MUL lower product / DIV quotient.
oZero  out  1  {oC_hi,oC_lo}==0.
oNeg  out  1  sign of the result (see Behaviour).
oDivZero  out  1  last DIV had iB==0.

Behaviour:
- Reset (nRst low, asynchronous): state IDLE; all outputs and internal registers are 0.
  - Reset mid-operation aborts the operation; no oDone is generated.
- Operand and iCtrl capture: captured on the accepting edge. Later input changes do not affect the operation in flight.
- States:
  - IDLE: iStart with a single-cycle op → compute, register results, go to DONE. iStart with MUL/DIV → load magnitudes and sign bits, counter=DATA_W-1, go to ITER. Undefined iCtrl → results 0, go to DONE.
  - ITER: one multiply or divide step per cycle. When counter==0 → FIX, otherwise decrement.
  - FIX: apply sign correction, register results and flags → DONE.
  - DONE: oDone=1 for this cycle only. Returns to IDLE. iStart sampled in DONE is accepted exactly as in IDLE (back-to-back operations).
- oBusy: 1 in ITER and FIX; 0 in IDLE and DONE.
- iStart while oBusy=1 is ignored; no queueing.
- Latency, counted in rising edges from the accepting edge to the first edge on which oDone=1 is visible:
  - single-cycle op: 1.
  - MUL/DIV: DATA_W+2.
- Output hold: results and flags hold their values until the next oDone. They do not change during ITER or FIX.
- ADD/SUB/NEG: two's complement modulo 2^DATA_W. NEG = 0−iA. oC_hi=0. oNeg = oC_lo[DATA_W-1].
- Logic ops (AND/OR/XOR/NOT): bitwise.
- Shifts and rotates:
  - SLL/SRL: logical shift.
  - SRA: shift-in is iA[DATA_W-1].
  - ROL/ROR: rotate by iB[SHAMT_W-1:0]. Shift amount 0 → iA unchanged.
- MUL:
  - Signed DATA_W×DATA_W → 2·DATA_W product on {oC_hi,oC_lo}.
  - Magnitudes are multiplied; the product is negated if sign(iA)^sign(iB).
  - Most-negative operands are handled (their magnitudes are treated as unsigned).
  - oNeg = oC_hi[DATA_W-1].
- DIV (signed, truncating toward zero):
  - oC_lo = quotient; oC_hi = remainder.
  - Remainder sign follows the dividend (iA); |remainder| < |divisor|.
  - oNeg = quotient sign bit.
  - Most-negative ÷ −1 → quotient = most-negative, remainder 0 (no trap).
- Divide by zero (iB==0):
  - Full DATA_W+2 latency is still taken.
  - oC_lo = all ones, oC_hi = iA, oDivZero=1.
  - oDivZero clears on the next oDone of any op.
- oZero is computed from the final registered {oC_hi,oC_lo}.

Test Plan:
1. Reset then ADD iA=5, iB=0xFFFFFFFB (DATA_W=32) → oDone 1 edge after start; oC_lo=0, oC_hi=0, oZero=1, oNeg=0, oBusy never high.
2. MUL iA=0xFFFFFFFD (−3), iB=7 → oBusy high for 33 cycles, oDone exactly 34 edges after start; oC_hi=0xFFFFFFFF, oC_lo=0xFFFFFFEB, oNeg=1. Repeat with iA=iB=0x80000000 → oC_hi=0x40000000, oC_lo=0.
3. DIV iA=0xFFFFFFF9 (−7), iB=2 → oC_lo=0xFFFFFFFD, oC_hi=0xFFFFFFFF, oNeg=1. DIV iA=7, iB=0xFFFFFFFE → oC_lo=0xFFFFFFFD, oC_hi=1.
4. DIV iA=0x1234, iB=0 → oC_lo=0xFFFFFFFF, oC_hi=0x1234, oDivZero=1 after 34 edges. A following XOR then clears oDivZero.
5. During MUL: toggle iA/iB/iCtrl and pulse iStart mid-ITER → result unchanged, only one oDone. iStart held in the oDone cycle with SRA iA=0x80000000, iB=4 → next oDone 1 edge later, oC_lo=0xF8000000.
6. Assert nRst low at cycle 10 of a DIV → outputs 0 immediately (asynchronous); no oDone after release. A new MUL 3×4 after release → oC_lo=12.
7. Repeat tests 2 and 3 with DATA_W=16 → latency 18 edges, results scaled accordingly.
